// File: rtl/dmem_refill_rv32_if.sv
// Word-wide memory-bus bundle between the refill engine and the memory.
// The engine drives a request that stays stable until the memory acks it;
// the ack may arrive in the same cycle as the request (zero-wait memory).
interface dmem_refill_rv32_if;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic [31:0] bus_rdata;
    logic        bus_ack;

    // Refill engine side
    modport master (
        output bus_req,
        output bus_we,
        output bus_addr,
        output bus_wdata,
        input  bus_rdata,
        input  bus_ack
    );

    // Memory side
    modport slave (
        input  bus_req,
        input  bus_we,
        input  bus_addr,
        input  bus_wdata,
        output bus_rdata,
        output bus_ack
    );
endinterface

// File: rtl/dmem_refill_rv32.sv
// Data-cache line refill engine for an RV32 core.
// On a miss it optionally writes the dirty victim line back word by word,
// then reads the missing line word by word, both in ascending word order,
// and pulses oFILLDONE for one cycle when the refilled line is complete.
module dmem_refill_rv32 #(
    parameter int LINE_WORDS = 4,
    parameter int OFS        = $clog2(LINE_WORDS) + 2
) (
    input  logic                    iCLK,
    input  logic                    iRST,
    // cache side
    input  logic                    iFILLREQ,
    input  logic [31:0]             iFILLADDR,
    input  logic                    iWBREQ,
    input  logic [31:0]             iWBADDR,
    input  logic [32*LINE_WORDS-1:0] iWBDATA,
    output logic [32*LINE_WORDS-1:0] oFILLDATA,
    output logic                    oFILLDONE,
    output logic                    oBUSY,
    // memory-bus side
    output logic                    oBUSREQ,
    output logic                    oBUSWE,
    output logic [31:0]             oBUSADDR,
    output logic [31:0]             oBUSWDATA,
    input  logic [31:0]             iBUSRDATA,
    input  logic                    iBUSACK
);

    localparam int              CW        = $clog2(LINE_WORDS);
    localparam logic [CW-1:0]   LAST_WORD = CW'(LINE_WORDS - 1);
    // Clears the byte-offset field so a line base is always line aligned.
    localparam logic [31:0]     LINE_MASK = ~((32'd1 << OFS) - 32'd1);

    typedef enum logic [1:0] {
        IDLE,
        WB,
        FILL,
        DONE
    } state_t;

    state_t                    state_q;
    logic [CW-1:0]             cnt_q;
    logic [31:0]               fill_base_q;
    logic [31:0]               wb_base_q;
    logic [32*LINE_WORDS-1:0]  wb_line_q;
    logic [32*LINE_WORDS-1:0]  fill_data_q;
    logic                      bus_req_q;
    // Set at accept time from iWBREQ: the victim still owes a write-back.
    // It is cleared when the write-back finishes, so it doubles as the
    // bus write-enable.
    logic                      bus_we_q;
    logic [31:0]               bus_addr_q;
    logic [31:0]               bus_wdata_q;
    logic                      busy_q;
    logic                      fill_done_q;

    logic [CW-1:0]             cnt_d;
    logic [31:0]               wb_addr_d;
    logic [31:0]               fill_addr_d;
    logic [31:0]               wb_word_d;
    logic                      ack_hit;
    logic                      last_word;

    // Values the bus registers take after an acked word moves the counter on.
    // NOTE: every signal written in always_comb gets a value on every path,
    // otherwise synthesis infers a latch to hold the old value.
    always_comb begin
        cnt_d       = cnt_q + CW'(1);
        wb_addr_d   = wb_base_q + (32'(cnt_d) << 2);
        fill_addr_d = fill_base_q + (32'(cnt_d) << 2);
        wb_word_d   = wb_line_q[32*cnt_d +: 32];
        ack_hit     = bus_req_q & iBUSACK;
        last_word   = (cnt_q == LAST_WORD);
    end

    // Refill FSM with registered bus, status and line outputs.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge iCLK) begin
        if (iRST) begin
            // NOTE: the line registers are reset too, because oFILLDATA is
            // a visible output that must read zero after reset; wb_line_q is
            // cleared only to keep the whole datapath deterministic.
            state_q     <= IDLE;
            cnt_q       <= '0;
            fill_base_q <= '0;
            wb_base_q   <= '0;
            wb_line_q   <= '0;
            fill_data_q <= '0;
            bus_req_q   <= 1'b0;
            bus_we_q    <= 1'b0;
            bus_addr_q  <= '0;
            bus_wdata_q <= '0;
            busy_q      <= 1'b0;
            fill_done_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    fill_done_q <= 1'b0;
                    if (iFILLREQ) begin
                        fill_base_q <= iFILLADDR & LINE_MASK;
                        wb_base_q   <= iWBADDR & LINE_MASK;
                        wb_line_q   <= iWBDATA;
                        cnt_q       <= '0;
                        busy_q      <= 1'b1;
                        bus_req_q   <= 1'b1;
                        bus_we_q    <= iWBREQ;
                        if (iWBREQ) begin
                            state_q     <= WB;
                            bus_addr_q  <= iWBADDR & LINE_MASK;
                            bus_wdata_q <= iWBDATA[31:0];
                        end else begin
                            state_q     <= FILL;
                            bus_addr_q  <= iFILLADDR & LINE_MASK;
                            bus_wdata_q <= '0;
                        end
                    end
                end

                WB: begin
                    // Request stays frozen until the memory acks the word.
                    if (ack_hit) begin
                        if (last_word) begin
                            state_q     <= FILL;
                            cnt_q       <= '0;
                            bus_we_q    <= 1'b0;
                            bus_addr_q  <= fill_base_q;
                            bus_wdata_q <= '0;
                        end else begin
                            cnt_q       <= cnt_d;
                            bus_addr_q  <= wb_addr_d;
                            bus_wdata_q <= wb_word_d;
                        end
                    end
                end

                FILL: begin
                    if (ack_hit) begin
                        fill_data_q[32*cnt_q +: 32] <= iBUSRDATA;
                        if (last_word) begin
                            state_q     <= DONE;
                            cnt_q       <= '0;
                            bus_req_q   <= 1'b0;
                            bus_addr_q  <= '0;
                            fill_done_q <= 1'b1;
                        end else begin
                            cnt_q      <= cnt_d;
                            bus_addr_q <= fill_addr_d;
                        end
                    end
                end

                DONE: begin
                    // Single-cycle completion pulse; the line stays in
                    // fill_data_q until the next FILL overwrites it.
                    state_q     <= IDLE;
                    fill_done_q <= 1'b0;
                    busy_q      <= 1'b0;
                end

                default: begin
                    state_q   <= IDLE;
                    bus_req_q <= 1'b0;
                    busy_q    <= 1'b0;
                end
            endcase
        end
    end

    assign oFILLDATA = fill_data_q;
    assign oFILLDONE = fill_done_q;
    assign oBUSY     = busy_q;
    assign oBUSREQ   = bus_req_q;
    assign oBUSWE    = bus_we_q;
    assign oBUSADDR  = bus_addr_q;
    assign oBUSWDATA = bus_wdata_q;

endmodule

// File: tb/tb_dmem_refill_rv32.sv
// Directed bench for dmem_refill_rv32: a per-cycle vector table for the
// clean and dirty refills, then hand-written sequences for wait states,
// requests while busy, reset mid-fill and back-to-back requests.
module tb_dmem_refill_rv32;

    localparam int LW = 4;

    typedef struct {
        logic          fillreq;
        logic [31:0]   filladdr;
        logic          wbreq;
        logic          ack;
        logic          e_req;
        logic          e_we;
        logic [31:0]   e_addr;
        logic [31:0]   e_wdata;
        logic          e_busy;
        logic          e_done;
        logic          chk_fd;
        logic [127:0]  e_fd;
    } vec_t;

    logic               clk;
    logic               rst;
    logic               fillreq;
    logic [31:0]        filladdr;
    logic               wbreq;
    logic [31:0]        wbaddr;
    logic [32*LW-1:0]   wbdata;
    logic [32*LW-1:0]   filldata;
    logic               filldone;
    logic               busy;
    logic               ack;
    logic               saw_80;

    int n_cmp;
    int n_err;

    vec_t vecs[$];

    dmem_refill_rv32_if bus_if ();

    // Memory model: returns the word address as read data.
    assign bus_if.bus_rdata = bus_if.bus_addr;
    assign bus_if.bus_ack   = ack;

    dmem_refill_rv32 #(.LINE_WORDS(LW)) dut (
        .iCLK      (clk),
        .iRST      (rst),
        .iFILLREQ  (fillreq),
        .iFILLADDR (filladdr),
        .iWBREQ    (wbreq),
        .iWBADDR   (wbaddr),
        .iWBDATA   (wbdata),
        .oFILLDATA (filldata),
        .oFILLDONE (filldone),
        .oBUSY     (busy),
        .oBUSREQ   (bus_if.bus_req),
        .oBUSWE    (bus_if.bus_we),
        .oBUSADDR  (bus_if.bus_addr),
        .oBUSWDATA (bus_if.bus_wdata),
        .iBUSRDATA (bus_if.bus_rdata),
        .iBUSACK   (bus_if.bus_ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Flags any completed bus transfer to 0x80 (must never happen).
    always @(negedge clk) begin
        if (bus_if.bus_req && bus_if.bus_ack && bus_if.bus_addr == 32'h80)
            saw_80 = 1'b1;
    end

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic vec_t mk(input logic fr, input logic [31:0] fa, input logic wr,
                                input logic ak, input logic er, input logic ew,
                                input logic [31:0] ea, input logic [31:0] ed,
                                input logic eb, input logic edn,
                                input logic cf, input logic [127:0] efd);
        vec_t v;
        v.fillreq = fr;  v.filladdr = fa; v.wbreq = wr;  v.ack = ak;
        v.e_req   = er;  v.e_we     = ew; v.e_addr = ea; v.e_wdata = ed;
        v.e_busy  = eb;  v.e_done   = edn;
        v.chk_fd  = cf;  v.e_fd     = efd;
        return v;
    endfunction

    // Expected refilled line when memory returns addresses as data.
    function automatic logic [127:0] line_of(input logic [31:0] base);
        return {base + 32'd12, base + 32'd8, base + 32'd4, base};
    endfunction

    localparam logic [31:0] A0 = 32'hA0A0_0000;
    localparam logic [31:0] A1 = 32'hA1A1_0001;
    localparam logic [31:0] A2 = 32'hA2A2_0002;
    localparam logic [31:0] A3 = 32'hA3A3_0003;
    localparam logic [127:0] CLEAN_LINE = 128'h0000123C_00001238_00001234_00001230;
    localparam logic [127:0] DIRTY_LINE = 128'h0000004C_00000048_00000044_00000040;

    initial begin
        n_cmp    = 0;
        n_err    = 0;
        saw_80   = 1'b0;
        rst      = 1'b1;
        fillreq  = 1'b0;
        filladdr = '0;
        wbreq    = 1'b0;
        wbaddr   = 32'h0000_2008;
        wbdata   = {A3, A2, A1, A0};
        ack      = 1'b0;

        // ---------------- reset state ----------------
        step();
        step();
        check("rst_busreq",   128'(bus_if.bus_req),   '0);
        check("rst_buswe",    128'(bus_if.bus_we),    '0);
        check("rst_busaddr",  128'(bus_if.bus_addr),  '0);
        check("rst_buswdata", 128'(bus_if.bus_wdata), '0);
        check("rst_filldata", filldata,               '0);
        check("rst_filldone", 128'(filldone),         '0);
        check("rst_busy",     128'(busy),             '0);
        rst = 1'b0;

        // ---------------- vector table ----------------
        //             fr  fa            wr ak  req we addr          wdata busy done chkfd fd
        // idle with a stray ack: nothing happens
        vecs.push_back(mk(0, 32'h0,        0, 1, 0, 0, 32'h0,      32'h0, 0, 0, 1, '0));
        // clean fill of 0x1234
        vecs.push_back(mk(1, 32'h0000_1234, 0, 1, 1, 0, 32'h1230,   32'h0, 1, 0, 0, '0));
        vecs.push_back(mk(0, 32'h0,        0, 1, 1, 0, 32'h1234,   32'h0, 1, 0, 0, '0));
        vecs.push_back(mk(0, 32'h0,        0, 1, 1, 0, 32'h1238,   32'h0, 1, 0, 0, '0));
        vecs.push_back(mk(0, 32'h0,        0, 1, 1, 0, 32'h123C,   32'h0, 1, 0, 0, '0));
        vecs.push_back(mk(0, 32'h0,        0, 1, 0, 0, 32'h0,      32'h0, 1, 1, 1, CLEAN_LINE));
        vecs.push_back(mk(0, 32'h0,        0, 1, 0, 0, 32'h0,      32'h0, 0, 0, 1, CLEAN_LINE));
        vecs.push_back(mk(0, 32'h0,        0, 0, 0, 0, 32'h0,      32'h0, 0, 0, 1, CLEAN_LINE));
        // dirty victim at 0x2008, then fill of 0x40
        vecs.push_back(mk(1, 32'h0000_0040, 1, 1, 1, 1, 32'h2000,   A0,    1, 0, 0, '0));
        vecs.push_back(mk(0, 32'h0,        0, 1, 1, 1, 32'h2004,   A1,    1, 0, 0, '0));
        vecs.push_back(mk(0, 32'h0,        0, 1, 1, 1, 32'h2008,   A2,    1, 0, 0, '0));
        vecs.push_back(mk(0, 32'h0,        0, 1, 1, 1, 32'h200C,   A3,    1, 0, 1, CLEAN_LINE));
        vecs.push_back(mk(0, 32'h0,        0, 1, 1, 0, 32'h40,     32'h0, 1, 0, 0, '0));
        vecs.push_back(mk(0, 32'h0,        0, 1, 1, 0, 32'h44,     32'h0, 1, 0, 0, '0));
        vecs.push_back(mk(0, 32'h0,        0, 1, 1, 0, 32'h48,     32'h0, 1, 0, 0, '0));
        vecs.push_back(mk(0, 32'h0,        0, 1, 1, 0, 32'h4C,     32'h0, 1, 0, 0, '0));
        vecs.push_back(mk(0, 32'h0,        0, 1, 0, 0, 32'h0,      32'h0, 1, 1, 1, DIRTY_LINE));
        vecs.push_back(mk(0, 32'h0,        0, 0, 0, 0, 32'h0,      32'h0, 0, 0, 1, DIRTY_LINE));

        foreach (vecs[i]) begin
            fillreq  = vecs[i].fillreq;
            filladdr = vecs[i].filladdr;
            wbreq    = vecs[i].wbreq;
            ack      = vecs[i].ack;
            step();
            check($sformatf("v%0d_busreq", i), 128'(bus_if.bus_req), 128'(vecs[i].e_req));
            check($sformatf("v%0d_busy", i),   128'(busy),           128'(vecs[i].e_busy));
            check($sformatf("v%0d_done", i),   128'(filldone),       128'(vecs[i].e_done));
            if (vecs[i].e_req) begin
                check($sformatf("v%0d_we", i),   128'(bus_if.bus_we),   128'(vecs[i].e_we));
                check($sformatf("v%0d_addr", i), 128'(bus_if.bus_addr), 128'(vecs[i].e_addr));
                if (vecs[i].e_we)
                    check($sformatf("v%0d_wdata", i), 128'(bus_if.bus_wdata), 128'(vecs[i].e_wdata));
            end
            if (vecs[i].chk_fd)
                check($sformatf("v%0d_filldata", i), filldata, vecs[i].e_fd);
        end
        fillreq = 1'b0;
        wbreq   = 1'b0;

        // ---------------- wait states: ack every third cycle ----------------
        ack      = 1'b0;
        fillreq  = 1'b1;
        filladdr = 32'h0000_0104;
        step();
        fillreq = 1'b0;
        check("ws_busreq", 128'(bus_if.bus_req), 128'(1));
        for (int w = 0; w < LW; w++) begin
            check($sformatf("ws_w%0d_addr", w), 128'(bus_if.bus_addr), 128'(32'h100 + 32'(4*w)));
            for (int k = 0; k < 2; k++) begin
                ack = 1'b0;
                step();
                check($sformatf("ws_w%0d_hold%0d_req", w, k),  128'(bus_if.bus_req),  128'(1));
                check($sformatf("ws_w%0d_hold%0d_addr", w, k), 128'(bus_if.bus_addr), 128'(32'h100 + 32'(4*w)));
                check($sformatf("ws_w%0d_hold%0d_we", w, k),   128'(bus_if.bus_we),   128'(0));
            end
            ack = 1'b1;
            step();
        end
        ack = 1'b0;
        check("ws_done",     128'(filldone), 128'(1));
        check("ws_filldata", filldata,       line_of(32'h100));
        step();
        check("ws_idle_busy", 128'(busy),    128'(0));

        // ---------------- request while busy ----------------
        saw_80   = 1'b0;
        ack      = 1'b1;
        fillreq  = 1'b1;
        filladdr = 32'h0000_0200;
        step();
        filladdr = 32'h0000_0080;
        step();
        fillreq = 1'b0;
        check("bz_addr", 128'(bus_if.bus_addr), 128'(32'h204));
        step();
        step();
        step();
        check("bz_done", 128'(filldone), 128'(1));
        step();
        check("bz_idle_busy", 128'(busy),  128'(0));
        check("bz_filldata",  filldata,    line_of(32'h200));
        check("bz_no_bus_80", 128'(saw_80), 128'(0));

        // ---------------- reset mid-FILL after two acks ----------------
        fillreq  = 1'b1;
        filladdr = 32'h0000_0300;
        step();
        fillreq = 1'b0;
        step();
        step();
        check("rm_addr_before", 128'(bus_if.bus_addr), 128'(32'h308));
        rst = 1'b1;
        ack = 1'b0;
        step();
        check("rm_busreq",   128'(bus_if.bus_req),   '0);
        check("rm_busy",     128'(busy),             '0);
        check("rm_filldata", filldata,               '0);
        check("rm_busaddr",  128'(bus_if.bus_addr),  '0);
        check("rm_buswe",    128'(bus_if.bus_we),    '0);
        rst = 1'b0;
        ack = 1'b1;
        step();
        step();
        check("rm_late_busreq",   128'(bus_if.bus_req), '0);
        check("rm_late_busy",     128'(busy),           '0);
        check("rm_late_done",     128'(filldone),       '0);
        check("rm_late_filldata", filldata,             '0);

        // ---------------- back-to-back requests ----------------
        fillreq  = 1'b1;
        filladdr = 32'h0000_0400;
        step();
        fillreq = 1'b0;
        for (int i = 0; i < LW; i++) step();
        check("bb_first_done", 128'(filldone), 128'(1));
        // Request raised while in DONE: ignored there, accepted from IDLE.
        fillreq  = 1'b1;
        filladdr = 32'h0000_0500;
        step();
        check("bb_idle_busreq", 128'(bus_if.bus_req), 128'(0));
        check("bb_idle_busy",   128'(busy),           128'(0));
        step();
        fillreq = 1'b0;
        check("bb_second_req",  128'(bus_if.bus_req),  128'(1));
        check("bb_second_addr", 128'(bus_if.bus_addr), 128'(32'h500));
        for (int i = 0; i < LW; i++) step();
        check("bb_second_done",     128'(filldone), 128'(1));
        check("bb_second_filldata", filldata,       line_of(32'h500));
        ack = 1'b0;
        step();
        check("bb_end_busy", 128'(busy), 128'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
